orbit_ctrl: RTL and testbench

Orbit-phase transmit scheduler for the avionics payload. Counts 10 Hz timing ticks while enabled, tracks the position within a fixed-length orbit period, and asserts `tx_enable` during a transmit window at the start of every orbit. It sits between the slow 10 Hz timebase and the radio/TX path. All logic runs on the 48 MHz system clock.

---
 rtl/orbit_ctrl_if.sv | 13 +
 rtl/orbit_ctrl.sv | 89 ++++++++
 tb/tb_orbit_ctrl.sv | 202 ++++++++++++++++++++
 3 files changed

// File: rtl/orbit_ctrl_if.sv
// Bus between the orbit scheduler and its environment: the 10 Hz
// timebase, the run enable, the transmit window and the orbit position.
interface orbit_ctrl_if #(
    parameter int CNT_W = 16
);
    logic             clk;          // 10 Hz timebase, sampled as data
    logic             cntr_enable;  // run enable, synchronous to CLK_48MHZ
    logic             tx_enable;    // transmit window active (registered)
    logic [CNT_W-1:0] count;        // orbit position in ticks (registered)

    modport master (output clk, output cntr_enable, input tx_enable, input count);
    modport slave  (input clk, input cntr_enable, output tx_enable, output count);
endinterface

// File: rtl/orbit_ctrl.sv
// Orbit-phase transmit scheduler: counts synchronized 10 Hz ticks while
// enabled, wraps every ORBIT_TICKS, and opens a TX window of TX_LEN ticks
// at the start of each orbit.
module orbit_ctrl #(
    parameter int ORBIT_TICKS = 54000,
    parameter int TX_LEN      = 6000,
    parameter int CNT_W       = 16
) (
    input  logic         CLK_48MHZ,
    input  logic         reset,
    orbit_ctrl_if.slave  bus
);
    typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(ORBIT_TICKS - 1);
    // One extra bit so TX_LEN == 2^CNT_W still compares correctly.
    localparam logic [CNT_W:0]   TX_LIM   = (CNT_W + 1)'(TX_LEN);

    state_t           r_state;
    logic             r_s1, r_s2, r_s3, r_tick;
    logic [CNT_W-1:0] r_count;
    logic             r_tx;
    logic [CNT_W-1:0] w_cnt_inc;
    logic             w_tx_inc;

    assign w_cnt_inc = r_count + CNT_W'(1);
    assign w_tx_inc  = ({1'b0, w_cnt_inc} < TX_LIM);

    // Synchronize the 10 Hz timebase and turn each rising edge into a
    // single-cycle tick; falling edges are ignored.
    always_ff @(posedge CLK_48MHZ or posedge reset) begin
        if (reset) begin
            r_s1   <= 1'b0;
            r_s2   <= 1'b0;
            r_s3   <= 1'b0;
            r_tick <= 1'b0;
        end else begin
            r_s1   <= bus.clk;
            r_s2   <= r_s1;
            r_s3   <= r_s2;
            r_tick <= r_s2 & ~r_s3;
        end
    end

    // IDLE/RUN state machine; tx_enable is registered from the next count
    // so it moves on the same edge as the count. Disable beats a tick.
    always_ff @(posedge CLK_48MHZ or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
            r_count <= '0;
            r_tx    <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    r_count <= '0;
                    if (bus.cntr_enable) begin
                        r_state <= RUN;   // a coincident tick is dropped
                        r_tx    <= 1'b1;
                    end else begin
                        r_tx    <= 1'b0;
                    end
                end
                RUN: begin
                    if (!bus.cntr_enable) begin
                        r_state <= IDLE;
                        r_count <= '0;
                        r_tx    <= 1'b0;
                    end else if (r_tick) begin
                        if (r_count == LAST_CNT) begin
                            r_count <= '0;
                            r_tx    <= 1'b1;
                        end else begin
                            r_count <= w_cnt_inc;
                            r_tx    <= w_tx_inc;
                        end
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_count <= '0;
                    r_tx    <= 1'b0;
                end
            endcase
        end
    end

    assign bus.tx_enable = r_tx;
    assign bus.count     = r_count;
endmodule

// File: tb/tb_orbit_ctrl.sv
// Bench for orbit_ctrl (ORBIT_TICKS=10, TX_LEN=3). Stimulus pushes each
// expected {tx_enable,count} change into a queue; a monitor pops and
// compares whenever the DUT outputs change.
module tb_orbit_ctrl;
    localparam int OT = 10;
    localparam int TL = 3;
    localparam int CW = 4;

    logic CLK_48MHZ = 1'b0;
    logic reset;
    always #5 CLK_48MHZ = ~CLK_48MHZ;

    orbit_ctrl_if #(.CNT_W(CW)) bus();
    orbit_ctrl #(.ORBIT_TICKS(OT), .TX_LEN(TL), .CNT_W(CW)) dut (
        .CLK_48MHZ (CLK_48MHZ),
        .reset     (reset),
        .bus       (bus)
    );

    int          total = 0;
    int          bad   = 0;
    logic [CW:0] q[$];
    logic        mon_on = 1'b0;
    logic [CW:0] prev;
    logic [CW:0] cur;
    logic [CW:0] exp_v;
    int          m_cnt;
    logic        m_tx;

    task automatic chk(input string name, input int act, input int req);
        total++;
        if (act != req) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", name, act, req);
        end
    endtask

    // Update the model and queue the change the monitor must see.
    task automatic expect_st(input logic tx, input int cnt);
        if (tx !== m_tx || cnt != m_cnt) q.push_back({tx, CW'(cnt)});
        m_tx  = tx;
        m_cnt = cnt;
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge CLK_48MHZ);
    endtask

    // One timebase pulse; when running, predicts the next state and
    // measures clk-rise to tx_enable-change latency.
    task automatic pulse(input int hi, input int lo, input logic run);
        int   nc;
        logic ntx;
        logic old_tx;
        int   lat;
        @(negedge CLK_48MHZ);
        old_tx = m_tx;
        nc     = (m_cnt == OT - 1) ? 0 : m_cnt + 1;
        ntx    = (nc < TL);
        if (run) expect_st(ntx, nc);
        bus.clk = 1'b1;
        lat = 0;
        for (int i = 1; i <= hi; i++) begin
            @(posedge CLK_48MHZ);
            #1;
            if (lat == 0 && bus.tx_enable == ntx) lat = i;
        end
        if (run && ntx != old_tx) begin
            total++;
            if (lat < 4 || lat > 5) begin
                bad++;
                $display("FAIL tx_latency: got %0d edges want 4..5", lat);
            end
        end
        @(negedge CLK_48MHZ);
        bus.clk = 1'b0;
        cyc(lo);
        if (run) begin
            chk("tick_count", int'(bus.count), nc);
            chk("tick_tx", int'(bus.tx_enable), int'(ntx));
        end
    endtask

    // Scoreboard monitor: every output change must match the queue head.
    always @(negedge CLK_48MHZ) begin
        if (mon_on) begin
            cur = {bus.tx_enable, bus.count};
            if (cur !== prev) begin
                total++;
                if (q.size() == 0) begin
                    bad++;
                    $display("FAIL unexpected_change: got tx=%0b cnt=%0d want no change",
                             cur[CW], cur[CW-1:0]);
                end else begin
                    exp_v = q.pop_front();
                    if (exp_v !== cur) begin
                        bad++;
                        $display("FAIL sb_change: got tx=%0b cnt=%0d want tx=%0b cnt=%0d",
                                 cur[CW], cur[CW-1:0], exp_v[CW], exp_v[CW-1:0]);
                    end
                end
                prev = cur;
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1;
        bus.clk = 1'b0;
        bus.cntr_enable = 1'b0;
        m_cnt = 0;
        m_tx  = 1'b0;
        cyc(3);
        chk("rst_tx", int'(bus.tx_enable), 0);
        chk("rst_cnt", int'(bus.count), 0);
        reset = 1'b0;
        cyc(3);
        chk("idle_tx", int'(bus.tx_enable), 0);
        prev   = '0;
        mon_on = 1'b1;

        // enable: tx_enable one edge later
        expect_st(1'b1, 0);
        bus.cntr_enable = 1'b1;
        @(posedge CLK_48MHZ); #1;
        chk("en_lat_tx", int'(bus.tx_enable), 1);
        chk("en_lat_cnt", int'(bus.count), 0);
        cyc(5);

        // window timing and wrap over three orbits
        for (int k = 1; k <= 3 * OT; k++) pulse(20, 20, 1'b1);
        pulse(20, 20, 1'b1);  // count = 1

        // asynchronous reset mid-cycle
        @(posedge CLK_48MHZ); #3;
        expect_st(1'b0, 0);
        reset = 1'b1;
        #1;
        chk("rst_async_tx", int'(bus.tx_enable), 0);
        cyc(3);
        expect_st(1'b1, 0);
        reset = 1'b0;
        @(posedge CLK_48MHZ); #1;
        chk("rst_rel_tx", int'(bus.tx_enable), 1);
        chk("rst_rel_cnt", int'(bus.count), 0);
        cyc(5);

        // disable mid-orbit at count 6
        for (int k = 1; k <= 6; k++) pulse(20, 20, 1'b1);
        @(negedge CLK_48MHZ);
        expect_st(1'b0, 0);
        bus.cntr_enable = 1'b0;
        @(posedge CLK_48MHZ); #1;
        chk("dis_tx", int'(bus.tx_enable), 0);
        chk("dis_cnt", int'(bus.count), 0);
        pulse(20, 20, 1'b0);
        cyc(58);
        chk("dis_ignore_cnt", int'(bus.count), 0);
        @(negedge CLK_48MHZ);
        expect_st(1'b1, 0);
        bus.cntr_enable = 1'b1;
        @(posedge CLK_48MHZ); #1;
        chk("reen_tx", int'(bus.tx_enable), 1);
        chk("reen_cnt", int'(bus.count), 0);
        cyc(5);

        // cntr_enable falls on the same edge that tick is high
        pulse(20, 20, 1'b1);  // count = 1
        @(negedge CLK_48MHZ);
        bus.clk = 1'b1;
        repeat (3) @(posedge CLK_48MHZ);  // tick now registered high
        @(negedge CLK_48MHZ);
        expect_st(1'b0, 0);
        bus.cntr_enable = 1'b0;
        @(posedge CLK_48MHZ); #1;
        chk("simul_cnt", int'(bus.count), 0);
        chk("simul_tx", int'(bus.tx_enable), 0);
        cyc(20);
        bus.clk = 1'b0;
        cyc(20);
        chk("simul_hold_cnt", int'(bus.count), 0);
        expect_st(1'b1, 0);
        bus.cntr_enable = 1'b1;
        cyc(5);

        // long high phase: exactly one increment, none on the fall
        pulse(1000, 40, 1'b1);
        cyc(40);
        chk("edge_filter_cnt", int'(bus.count), 1);

        cyc(5);
        chk("queue_empty", q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
